gain_channel_scheduler: RTL and testbench
=========================================

Name: gain_channel_scheduler

Overview:
Decides which of the two ADC gain channels feeds the progressive channel mux. It drives the `select` input of the channel combinator: c1 is the high-gain channel, c2 is the low-gain channel. It switches to c2 immediately on c1 overload, returns to c1 only after a sustained quiet period, and enforces a transition window while the alpha sequence ramps. All decisions are made on the 3 MHz sample strobe.

Parameters:
HI_THRESH, 960, |c1| at or above this value is c1 overload (11-bit unsigned magnitude)
LO_THRESH, 384, |c2| strictly below this value is a quiet sample
RETURN_HOLD, 256, consecutive quiet samples required before returning to c1 (range 1..65535)
TRANSITION_LEN, 16, samples during which no new decision is taken after a select change (matches 16-step alpha ramp)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable_3M  in  1  one-clk sample strobe; all state advances only when high
data_c1  in  11  high-gain channel sample, two's complement
data_c2  in  11  low-gain channel sample, two's complement
select  out  1  0 = c1, 1 = c2; connects to the combinator select
in_transition  out  1  high while the transition window is running
overload_pulse  out  1  one-clk pulse on the strobe where a c1 overload causes a switch to c2

Behaviour:
- Reset values: select=0, in_transition=0, overload_pulse=0, state=SEL_C1, quiet counter=0, transition counter=0.
- Magnitude: |x| is computed combinationally as an 11-bit unsigned value. -1024 maps to 1024 with no saturation. Thresholds compare against this magnitude.
- All registers update only on clk edges where enable_3M=1. The exception is overload_pulse, which clears on the next clk regardless of the strobe.
- States:
  - SEL_C1: if |c1|>=HI_THRESH, set select=1, overload_pulse=1, load transition counter=TRANSITION_LEN, go to TRANS_TO_C2.
  - TRANS_TO_C2: decrement the counter each strobe. When the counter reaches 0 on a strobe, go to SEL_C2 with quiet counter=0. Overloads are ignored, since c2 is already selected.
  - SEL_C2: on a strobe with |c2|<LO_THRESH, increment the quiet counter; otherwise clear it to 0.
    - When an increment makes the count equal RETURN_HOLD, set select=0, load the transition counter, go to TRANS_TO_C1.
    - The quiet counter is 16 bits wide and never exceeds RETURN_HOLD.
  - TRANS_TO_C1: decrement the counter each strobe and go to SEL_C1 at 0.
    - Abort: if |c1|>=HI_THRESH on any strobe in this state, set select=1, overload_pulse=1, reload the counter, go to TRANS_TO_C2. Abort takes priority over counter expiry on the same strobe.
- in_transition = 1 exactly in TRANS_TO_C2 and TRANS_TO_C1 (registered with the state).
- Latency: select changes on the same clk edge as the strobe carrying the triggering sample (one register stage).
- Transition timing: a select change is followed by exactly TRANSITION_LEN strobes of in_transition=1 before the next decision strobe.
- enable_3M low: all state, counters and outputs hold, except that overload_pulse still clears.
- Reset asserted mid-transition: immediately returns to SEL_C1 with select=0. The combinator is reset by the same net.

Optional Feature:
Macro: GAIN_SCHED_FORCE_EN.
- Defined: adds inputs force_en (1) and force_sel (1).
  - While force_en=1, select=force_sel on the next strobe, the state jumps to SEL_C1 or SEL_C2 accordingly, counters clear, in_transition=0 and overload_pulse=0.
  - On release, automatic control resumes from that state.
- Undefined: the ports do not exist and the behaviour is purely automatic.

Test Plan:
- Reset, then 10 strobes with c1=100, c2=20 -> select=0, in_transition=0, overload_pulse never asserted.
- From SEL_C1, one strobe with c1=-1000 -> select=1 on that edge, overload_pulse high for exactly one clk, in_transition high for 16 strobes, then state SEL_C2.
- In SEL_C2, feed c2=100 for 255 strobes, then c2=400, then c2=100 for 256 strobes -> select returns to 0 only on the 256th quiet strobe after the 400 sample.
- 3 strobes into TRANS_TO_C1, apply c1=960 -> select=1, overload_pulse, in_transition stays high, counter restarts at 16.
- Assert reset at strobe 8 of TRANS_TO_C2 -> select=0, in_transition=0 asynchronously; after release, c1=-1024 triggers a switch, since |c1|=1024.
- With GAIN_SCHED_FORCE_EN defined: force_en=1, force_sel=1 during SEL_C1 -> select=1 next strobe, in_transition=0; release with c2=0 -> return to c1 after 256 strobes.

Source files
------------

// File: rtl/gain_channel_scheduler.sv
// gain_channel_scheduler: picks the high-gain (c1) or low-gain (c2) ADC channel, with a timed window around each change. Optional manual override under GAIN_SCHED_FORCE_EN.
module gain_channel_scheduler #(
  parameter int HI_THRESH      = 960,
  parameter int LO_THRESH      = 384,
  parameter int RETURN_HOLD    = 256,
  parameter int TRANSITION_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_3M,
  input  logic [10:0] data_c1,
  input  logic [10:0] data_c2,
`ifdef GAIN_SCHED_FORCE_EN
  input  logic        force_en,
  input  logic        force_sel,
`endif
  output logic        select,
  output logic        in_transition,
  output logic        overload_pulse
);
  typedef enum logic [1:0] {SEL_C1, TRANS_TO_C2, SEL_C2, TRANS_TO_C1} state_t;
  localparam int TW = $clog2(TRANSITION_LEN + 1);
  localparam logic [TW-1:0] TLEN = TW'(TRANSITION_LEN);
  localparam logic [15:0] RHOLD = 16'(RETURN_HOLD);
  state_t        r_state;
  logic [15:0]   r_quiet;
  logic [TW-1:0] r_tcnt;
  logic [10:0]   w_mag_c1, w_mag_c2;
  logic [15:0]   w_quiet_inc;
  logic          w_ovl, w_quiet, w_tlast;
  // -1024 negates to itself, which reads as 1024 when taken as unsigned
  assign w_mag_c1    = data_c1[10] ? -data_c1 : data_c1;
  assign w_mag_c2    = data_c2[10] ? -data_c2 : data_c2;
  assign w_ovl       = w_mag_c1 >= 11'(HI_THRESH);
  assign w_quiet     = w_mag_c2 < 11'(LO_THRESH);
  assign w_quiet_inc = r_quiet + 16'd1;
  assign w_tlast     = r_tcnt == TW'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= SEL_C1;
      r_quiet        <= '0;
      r_tcnt         <= '0;
      select         <= 1'b0;
      in_transition  <= 1'b0;
      overload_pulse <= 1'b0;
    end else begin
      overload_pulse <= 1'b0;
      if (enable_3M) begin
`ifdef GAIN_SCHED_FORCE_EN
        if (force_en) begin
          select        <= force_sel;
          r_state       <= force_sel ? SEL_C2 : SEL_C1;
          r_quiet       <= '0;
          r_tcnt        <= '0;
          in_transition <= 1'b0;
        end else
`endif
        case (r_state)
          SEL_C1: if (w_ovl) begin
            select         <= 1'b1;
            overload_pulse <= 1'b1;
            r_tcnt         <= TLEN;
            in_transition  <= 1'b1;
            r_state        <= TRANS_TO_C2;
          end
          TRANS_TO_C2: begin
            r_tcnt <= r_tcnt - TW'(1);
            if (w_tlast) begin
              r_state       <= SEL_C2;
              r_quiet       <= '0;
              in_transition <= 1'b0;
            end
          end
          SEL_C2: if (!w_quiet) r_quiet <= '0;
          else if (w_quiet_inc == RHOLD) begin
            r_quiet       <= '0;
            select        <= 1'b0;
            r_tcnt        <= TLEN;
            in_transition <= 1'b1;
            r_state       <= TRANS_TO_C1;
          end else r_quiet <= w_quiet_inc;
          TRANS_TO_C1: if (w_ovl) begin
            select         <= 1'b1;
            overload_pulse <= 1'b1;
            r_tcnt         <= TLEN;
            r_state        <= TRANS_TO_C2;
          end else begin
            r_tcnt <= r_tcnt - TW'(1);
            if (w_tlast) begin
              r_state       <= SEL_C1;
              in_transition <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gain_channel_scheduler.sv
// tb_gain_channel_scheduler: directed strobes push expected {select,in_transition,overload_pulse}; a monitor checks every clk edge and every reset assertion.
module tb_gain_channel_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_3M = 1'b0;
  logic [10:0] data_c1 = '0;
  logic [10:0] data_c2 = '0;
`ifdef GAIN_SCHED_FORCE_EN
  logic        force_en = 1'b0;
  logic        force_sel = 1'b0;
`endif
  logic        select, in_transition, overload_pulse;
  logic [2:0]  exp_q[$];
  logic        m_en;
  logic [2:0]  m_e, m_last;
  int          errors = 0;
  int          checks = 0;

  gain_channel_scheduler dut (
    .clk(clk), .reset(reset), .enable_3M(enable_3M),
    .data_c1(data_c1), .data_c2(data_c2),
`ifdef GAIN_SCHED_FORCE_EN
    .force_en(force_en), .force_sel(force_sel),
`endif
    .select(select), .in_transition(in_transition), .overload_pulse(overload_pulse)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [2:0] a, input logic [2:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: sel/trans/pulse got %b expected %b at %0t", n, a, e, $time);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    m_en = enable_3M;
    #1;
    if (!reset) begin
      chk("reset", {select, in_transition, overload_pulse}, 3'b000);
      m_last = 3'b000;
    end else if (m_en) begin
      if (exp_q.size() == 0) begin
        chk("underflow", {select, in_transition, overload_pulse}, 3'bxxx);
      end else begin
        m_e = exp_q.pop_front();
        chk("strobe", {select, in_transition, overload_pulse}, m_e);
        m_last = {m_e[2:1], 1'b0};
      end
    end else chk("hold", {select, in_transition, overload_pulse}, m_last);
  end

  task automatic strobe(input logic [10:0] c1, input logic [10:0] c2,
                        input logic s, input logic t, input logic p);
    @(negedge clk);
    data_c1 = c1;
    data_c2 = c2;
    enable_3M = 1'b1;
    exp_q.push_back({s, t, p});
    @(negedge clk);
    enable_3M = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) strobe(11'd100, 11'd20, 0, 0, 0);
    data_c1 = 11'(-1000);
    repeat (3) @(negedge clk);
`ifdef GAIN_SCHED_FORCE_EN
    force_en = 1'b1;
    force_sel = 1'b1;
    strobe(11'd0, 11'd0, 1, 0, 0);
    force_en = 1'b0;
    for (int i = 0; i < 256; i++) strobe(11'd0, 11'd0, i == 255 ? 0 : 1, i == 255, 0);
    for (int i = 0; i < 16; i++) strobe(11'd0, 11'd0, 0, i < 15, 0);
`endif
    strobe(11'(-1000), 11'd20, 1, 1, 1);
    for (int i = 0; i < 16; i++) strobe(11'(-1000), 11'd500, 1, i < 15, 0);
    for (int i = 0; i < 255; i++) strobe(11'd0, 11'd100, 1, 0, 0);
    strobe(11'd0, 11'd384, 1, 0, 0);
    for (int i = 0; i < 10; i++) strobe(11'd0, 11'(-383), 1, 0, 0);
    strobe(11'd0, 11'd400, 1, 0, 0);
    for (int i = 0; i < 256; i++)
      strobe(11'd0, i[0] ? 11'(-383) : 11'd100, i == 255 ? 0 : 1, i == 255, 0);
    for (int i = 0; i < 3; i++) strobe(11'd959, 11'd0, 0, 1, 0);
    strobe(11'd960, 11'd0, 1, 1, 1);
    for (int i = 0; i < 16; i++) strobe(11'd0, 11'd500, 1, i < 15, 0);
    for (int i = 0; i < 256; i++) strobe(11'd0, 11'd0, i == 255 ? 0 : 1, i == 255, 0);
    for (int i = 0; i < 16; i++) strobe(11'd0, 11'd0, 0, i < 15, 0);
    strobe(11'd1000, 11'd0, 1, 1, 1);
    for (int i = 0; i < 7; i++) strobe(11'd0, 11'd0, 1, 1, 0);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    strobe(11'(-1024), 11'd0, 1, 1, 1);
    for (int i = 0; i < 16; i++) strobe(11'd0, 11'd500, 1, i < 15, 0);
    strobe(11'(-1024), 11'd500, 1, 0, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
